// File: rtl/pe_stg_gen_if.sv
// Control, activation and column-bus signals of one top-row processing element.
interface pe_stg_gen_if #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TOP_WIDTH = 48,
  parameter int unsigned YSEL_W    = 1
);
  logic [1:0]           mode_sel_in;
  logic [YSEL_W-1:0]    y_sel_in;
  logic [CNT_W-1:0]     acc_len_in;
  logic                 psu_clr_in;
  logic                 valid_in;
  logic                 sys_buf_en_in;
  logic [A_WIDTH-1:0]   left_in;
  logic [A_WIDTH-1:0]   right_out;
  logic                 valid_out;
  logic [TOP_WIDTH-1:0] top_in;
  logic [TOP_WIDTH-1:0] bottom_out;
  logic                 bottom_valid_out;
  logic                 acc_done_out;
  logic                 drain_full_out;
  logic                 ovf_err_out;

  modport master (
    output mode_sel_in, y_sel_in, acc_len_in, psu_clr_in, valid_in, sys_buf_en_in,
           left_in, top_in,
    input  right_out, valid_out, bottom_out, bottom_valid_out, acc_done_out,
           drain_full_out, ovf_err_out
  );

  modport slave (
    input  mode_sel_in, y_sel_in, acc_len_in, psu_clr_in, valid_in, sys_buf_en_in,
           left_in, top_in,
    output right_out, valid_out, bottom_out, bottom_valid_out, acc_done_out,
           drain_full_out, ovf_err_out
  );
endinterface

// File: rtl/pe_stg_gen.sv
// Top-row systolic PE: multi-lane signed MAC with programmable depth, drain shift chain,
// and bf16 pre-processing for the downstream fp stages.
module pe_stg_gen #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned Y_WIDTH   = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned Y_BANKS   = 2,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TOP_WIDTH = 48,
  parameter int unsigned YSEL_W    = (Y_BANKS > 1) ? $clog2(Y_BANKS) : 1
) (
  input logic         clk,
  input logic         rst_n,
  pe_stg_gen_if.slave bus
);
  localparam int unsigned P_W    = A_WIDTH + Y_WIDTH;
  localparam int unsigned BANK_W = LANES * Y_WIDTH;
  localparam int unsigned DRN_W  = LANES * ACC_W;

  logic [A_WIDTH-1:0]            right_q;
  logic                          valid_q;
  logic [TOP_WIDTH-1:0]          bottom_q;
  logic                          bvalid_q;
  logic                          done_q;
  logic                          full_q;
  logic                          ovf_q;
  logic [LANES-1:0][P_W-1:0]     prod_q;
  logic                          prod_v_q;
  logic [LANES-1:0][ACC_W-1:0]   acc_q;
  logic [LANES-1:0][ACC_W-1:0]   drain_q;
  logic [CNT_W-1:0]              cnt_q;

  logic [BANK_W-1:0]             bank_c;
  logic [Y_WIDTH-1:0]            y_c;
  logic [P_W-1:0]                a_ext_c;
  logic [P_W-1:0]                y_ext_c;
  logic [LANES-1:0][P_W-1:0]     prod_c;
  logic [LANES-1:0][ACC_W-1:0]   sum_c;
  logic [CNT_W-1:0]              cnt_inc_c;
  logic                          mm_valid_c;
  logic                          last_c;
  logic                          done_c;
  logic [15:0]                   alpha_c;
  logic [15:0]                   beta_c;
  logic [9:0]                    r_c;
  logic [15:0]                   mag_c;
  logic [TOP_WIDTH-1:0]          bottom_d;
  logic                          bvalid_d;

  // bf16 mantissa with hidden bit, as a 9-bit two's-complement value
  function automatic logic [8:0] man9(input logic [15:0] x);
    logic [8:0] mag;
    mag = {2'b01, x[6:0]};
    return x[15] ? (~mag + 9'd1) : mag;
  endfunction

  // Weight bank select and per-lane products (operands sign-extended, so low bits are exact)
  always_comb begin
    bank_c  = '0;
    y_c     = '0;
    y_ext_c = '0;
    prod_c  = '0;
    for (int unsigned b = 0; b < Y_BANKS; b++) begin
      if (bus.y_sel_in == YSEL_W'(b)) bank_c = bus.top_in[b*BANK_W +: BANK_W];
    end
    a_ext_c = {{Y_WIDTH{bus.left_in[A_WIDTH-1]}}, bus.left_in};
    for (int unsigned l = 0; l < LANES; l++) begin
      y_c       = bank_c[l*Y_WIDTH +: Y_WIDTH];
      y_ext_c   = {{A_WIDTH{y_c[Y_WIDTH-1]}}, y_c};
      prod_c[l] = a_ext_c * y_ext_c;
    end
  end

  // Accumulate the in-flight product; completion when it is the N-th of the group
  always_comb begin
    sum_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sum_c[l] = acc_q[l] + {{(ACC_W-P_W){prod_q[l][P_W-1]}}, prod_q[l]};
    end
    cnt_inc_c  = cnt_q + CNT_W'(1);
    mm_valid_c = bus.valid_in && (bus.mode_sel_in == 2'b00);
    last_c     = prod_v_q && (cnt_inc_c == bus.acc_len_in);
    done_c     = last_c && !bus.psu_clr_in;
  end

  // Column output: drain unload first, otherwise pass-through or fp pre-processing
  always_comb begin
    alpha_c  = bus.top_in[15:0];
    beta_c   = bus.top_in[31:16];
    r_c      = (bus.mode_sel_in == 2'b10) ?
               ({2'b00, alpha_c[14:7]} + {2'b00, beta_c[14:7]} - 10'd127) :
               ({2'b00, alpha_c[14:7]} - {2'b00, beta_c[14:7]});
    mag_c    = 16'h5F37 - {1'b0, alpha_c[15:1]};
    bottom_d = '0;
    bvalid_d = 1'b0;
    if (bus.sys_buf_en_in) begin
      bottom_d = TOP_WIDTH'(drain_q);
      bvalid_d = 1'b1;
    end else begin
      case (bus.mode_sel_in)
        2'b00: bottom_d = bus.top_in;
        2'b01: begin
          bottom_d = TOP_WIDTH'(mag_c);
          bvalid_d = bus.valid_in;
        end
        default: begin
          bottom_d = TOP_WIDTH'({beta_c[14:7], alpha_c[14:7], r_c, man9(beta_c), man9(alpha_c)});
          bvalid_d = bus.valid_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_q  <= '0;
      valid_q  <= 1'b0;
      bottom_q <= '0;
      bvalid_q <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      drain_q  <= '0;
      cnt_q    <= '0;
    end else begin
      right_q  <= bus.left_in;
      valid_q  <= bus.valid_in;
      bottom_q <= bottom_d;
      bvalid_q <= bvalid_d;
      done_q   <= done_c;
      if (bus.psu_clr_in) begin
        prod_v_q <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        prod_v_q <= mm_valid_c;
        if (mm_valid_c) prod_q <= prod_c;
        if (last_c) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else if (prod_v_q) begin
          acc_q <= sum_c;
          cnt_q <= cnt_inc_c;
        end
      end
      // A completion always owns the drain; anything it displaces is flagged
      if (done_c) begin
        drain_q <= sum_c;
        full_q  <= 1'b1;
        if (full_q || bus.sys_buf_en_in) ovf_q <= 1'b1;
      end else if (bus.sys_buf_en_in) begin
        drain_q <= bus.top_in[DRN_W-1:0];
        full_q  <= 1'b0;
      end
    end
  end

  assign bus.right_out        = right_q;
  assign bus.valid_out        = valid_q;
  assign bus.bottom_out       = bottom_q;
  assign bus.bottom_valid_out = bvalid_q;
  assign bus.acc_done_out     = done_q;
  assign bus.drain_full_out   = full_q;
  assign bus.ovf_err_out      = ovf_q;
endmodule

// File: tb/tb_pe_stg_gen.sv
// Self-checking bench for pe_stg_gen: directed scenarios plus randomized MAC and fp traffic.
module tb_pe_stg_gen;
  localparam int unsigned A_W     = 8;
  localparam int unsigned Y_W     = 8;
  localparam int unsigned LANES   = 2;
  localparam int unsigned Y_BANKS = 2;
  localparam int unsigned ACC_W   = 24;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TOP_W   = 48;
  localparam int unsigned YSEL_W  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pe_stg_gen_if #(.A_WIDTH(A_W), .CNT_W(CNT_W), .TOP_WIDTH(TOP_W), .YSEL_W(YSEL_W)) bus ();

  pe_stg_gen #(
    .A_WIDTH(A_W), .Y_WIDTH(Y_W), .LANES(LANES), .Y_BANKS(Y_BANKS), .ACC_W(ACC_W),
    .CNT_W(CNT_W), .TOP_WIDTH(TOP_W), .YSEL_W(YSEL_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mode_sel_in   = 2'b00;
    bus.y_sel_in      = '0;
    bus.acc_len_in    = '0;
    bus.psu_clr_in    = 1'b0;
    bus.valid_in      = 1'b0;
    bus.sys_buf_en_in = 1'b0;
    bus.left_in       = '0;
    bus.top_in        = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expected drain image: each lane's exact sum wrapped to ACC_W, lane 0 in the LSBs
  function automatic logic [TOP_W-1:0] pack_drain(input longint s [LANES]);
    logic [TOP_W-1:0] r;
    logic [63:0]      v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      v = 64'(s[l]);
      r[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [TOP_W-1:0] pack_w(input logic signed [Y_W-1:0] w [Y_BANKS][LANES]);
    logic [TOP_W-1:0] r;
    r = '0;
    for (int b = 0; b < Y_BANKS; b++)
      for (int l = 0; l < LANES; l++) r[(b*LANES+l)*Y_W +: Y_W] = w[b][l];
    return r;
  endfunction

  // bf16 field arithmetic done on plain integers
  function automatic logic [TOP_W-1:0] fp_model(input logic [1:0] m, input logic [15:0] a,
                                                input logic [15:0] b);
    int ea, eb, ma, mb, r, mg;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = (a[15] ? -1 : 1) * (128 + int'(a[6:0]));
    mb = (b[15] ? -1 : 1) * (128 + int'(b[6:0]));
    if (m == 2'b01) begin
      mg = 'h5F37 - int'(a[15:1]);
      return TOP_W'(mg[15:0]);
    end
    r = (m == 2'b10) ? (ea + eb - 127) : (ea - eb);
    return TOP_W'({eb[7:0], ea[7:0], r[9:0], mb[8:0], ma[8:0]});
  endfunction

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.right_out, bus.valid_out, bus.bottom_out, bus.bottom_valid_out, bus.acc_done_out,
         bus.drain_full_out, bus.ovf_err_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bottom=%h right=%h flags=%b%b%b%b%b exp all 0",
               bus.bottom_out, bus.right_out, bus.valid_out, bus.bottom_valid_out,
               bus.acc_done_out, bus.drain_full_out, bus.ovf_err_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [TOP_W-1:0] chain;
    do_reset();
    bus.acc_len_in = CNT_W'(4);
    bus.top_in     = {16'h0, 8'h55, 8'h66, 8'hFE, 8'h03};
    for (int i = 1; i <= 4; i++) begin
      bus.left_in  = A_W'(i);
      bus.valid_in = 1'b1;
      tick();
    end
    bus.valid_in = 1'b0;
    checks++;
    if (bus.acc_done_out !== 1'b0) begin
      errors++; $display("FAIL basic_done_early got=%b exp=0", bus.acc_done_out);
    end
    tick();
    checks++;
    if (bus.acc_done_out !== 1'b1 || bus.drain_full_out !== 1'b1 || bus.ovf_err_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b full=%b ovf=%b exp 1 1 0",
               bus.acc_done_out, bus.drain_full_out, bus.ovf_err_out);
    end
    chain             = {$urandom, $urandom};
    bus.top_in        = chain;
    bus.sys_buf_en_in = 1'b1;
    tick();
    checks++;
    if (bus.bottom_out !== 48'hFFFFEC_00001E || bus.bottom_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_unload got=%h v=%b exp=%h v=1", bus.bottom_out,
               bus.bottom_valid_out, 48'hFFFFEC_00001E);
    end
    checks++;
    if (bus.drain_full_out !== 1'b0 || bus.acc_done_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_unload got full=%b done=%b exp 0 0",
               bus.drain_full_out, bus.acc_done_out);
    end
    bus.top_in = '0;
    tick();
    checks++;
    if (bus.bottom_out !== chain) begin
      errors++; $display("FAIL chain_hop got=%h exp=%h", bus.bottom_out, chain);
    end
    bus.sys_buf_en_in = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [TOP_W-1:0] t;
    logic [A_W-1:0]   a;
    logic             v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      t = {$urandom, $urandom};
      a = A_W'($urandom);
      v = 1'($urandom);
      bus.top_in   = t;
      bus.left_in  = a;
      bus.valid_in = v;
      tick();
      checks++;
      if (bus.bottom_out !== t || bus.bottom_valid_out !== 1'b0 || bus.right_out !== a ||
          bus.valid_out !== v) begin
        errors++;
        $display("FAIL passthrough got b=%h bv=%b r=%h v=%b exp b=%h bv=0 r=%h v=%b",
                 bus.bottom_out, bus.bottom_valid_out, bus.right_out, bus.valid_out, t, a, v);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_fp();
    logic [1:0]       m;
    logic [15:0]      a, b;
    logic             v;
    logic [TOP_W-1:0] e;
    do_reset();
    bus.top_in   = {16'h0, 16'hC000, 16'h3F80};
    bus.valid_in = 1'b1;
    bus.mode_sel_in = 2'b10;
    tick();
    e = {4'h0, 8'd128, 8'd127, 10'd128, 9'h180, 9'h080};
    checks++;
    if (bus.bottom_out !== e || bus.bottom_valid_out !== 1'b1) begin
      errors++; $display("FAIL fp_mul got=%h v=%b exp=%h v=1", bus.bottom_out, bus.bottom_valid_out, e);
    end
    bus.mode_sel_in = 2'b11;
    tick();
    e = {4'h0, 8'd128, 8'd127, 10'h3FF, 9'h180, 9'h080};
    checks++;
    if (bus.bottom_out !== e) begin
      errors++; $display("FAIL fp_add got=%h exp=%h", bus.bottom_out, e);
    end
    bus.mode_sel_in = 2'b01;
    tick();
    checks++;
    if (bus.bottom_out !== 48'h3F77 || bus.bottom_valid_out !== 1'b1) begin
      errors++; $display("FAIL fp_mag got=%h v=%b exp=3f77 v=1", bus.bottom_out, bus.bottom_valid_out);
    end
    for (int i = 0; i < 16; i++) begin
      m = 2'($urandom_range(1, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      v = 1'($urandom);
      bus.mode_sel_in = m;
      bus.top_in      = {16'($urandom), b, a};
      bus.valid_in    = v;
      tick();
      e = fp_model(m, a, b);
      checks++;
      if (bus.bottom_out !== e || bus.bottom_valid_out !== v) begin
        errors++;
        $display("FAIL fp_rand mode=%0d a=%h b=%h got=%h v=%b exp=%h v=%b", m, a, b,
                 bus.bottom_out, bus.bottom_valid_out, e, v);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    do_reset();
    bus.acc_len_in = CNT_W'(4);
    bus.top_in     = {32'h0, 8'hFE, 8'h03};
    bus.valid_in   = 1'b1;
    bus.left_in    = 8'd7;
    tick();
    bus.left_in    = 8'd9;
    tick();
    bus.valid_in   = 1'b0;
    bus.psu_clr_in = 1'b1;
    tick();
    bus.psu_clr_in = 1'b0;
    bus.left_in    = 8'd1;
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      tick();
      checks++;
      if (bus.acc_done_out !== 1'b0) begin
        errors++; $display("FAIL clear_done_early beat=%0d got=%b exp=0", i, bus.acc_done_out);
      end
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.acc_done_out !== 1'b1) begin
      errors++; $display("FAIL clear_done got=%b exp=1", bus.acc_done_out);
    end
    bus.sys_buf_en_in = 1'b1;
    tick();
    bus.sys_buf_en_in = 1'b0;
    checks++;
    if (bus.bottom_out !== 48'hFFFFF8_00000C) begin
      errors++; $display("FAIL clear_drain got=%h exp=%h", bus.bottom_out, 48'hFFFFF8_00000C);
    end
  endtask

  task automatic test_collision();
    longint s [LANES];
    logic [TOP_W-1:0] e;
    do_reset();
    bus.acc_len_in = CNT_W'(1);
    bus.top_in     = {32'h0, 8'd3, 8'd2};
    bus.left_in    = 8'd5;
    bus.valid_in   = 1'b1;
    tick();
    bus.valid_in   = 1'b0;
    tick();
    bus.left_in    = 8'hFC;
    bus.valid_in   = 1'b1;
    tick();
    checks++;
    if (bus.drain_full_out !== 1'b1 || bus.ovf_err_out !== 1'b0) begin
      errors++;
      $display("FAIL collide_pre got full=%b ovf=%b exp 1 0", bus.drain_full_out, bus.ovf_err_out);
    end
    bus.valid_in      = 1'b0;
    bus.sys_buf_en_in = 1'b1;
    bus.top_in        = {$urandom, $urandom};
    tick();
    s = '{10, 15};
    e = pack_drain(s);
    checks++;
    if (bus.bottom_out !== e || bus.acc_done_out !== 1'b1 || bus.ovf_err_out !== 1'b1 ||
        bus.drain_full_out !== 1'b1) begin
      errors++;
      $display("FAIL collide got=%h done=%b ovf=%b full=%b exp=%h 1 1 1", bus.bottom_out,
               bus.acc_done_out, bus.ovf_err_out, bus.drain_full_out, e);
    end
    bus.top_in = '0;
    tick();
    s = '{-8, -12};
    e = pack_drain(s);
    checks++;
    if (bus.bottom_out !== e || bus.drain_full_out !== 1'b0 || bus.ovf_err_out !== 1'b1) begin
      errors++;
      $display("FAIL collide_keep got=%h full=%b ovf=%b exp=%h 0 1", bus.bottom_out,
               bus.drain_full_out, bus.ovf_err_out, e);
    end
    bus.sys_buf_en_in = 1'b0;
  endtask

  task automatic test_overflow();
    logic signed [Y_W-1:0] w [Y_BANKS][LANES];
    logic signed [A_W-1:0] a;
    longint s [LANES];
    logic exp_done;
    do_reset();
    for (int b = 0; b < Y_BANKS; b++)
      for (int l = 0; l < LANES; l++) w[b][l] = Y_W'($urandom);
    bus.top_in     = pack_w(w);
    bus.acc_len_in = CNT_W'(4);
    for (int l = 0; l < LANES; l++) s[l] = 0;
    for (int c = 0; c < 11; c++) begin
      bus.valid_in = (c < 8);
      if (c < 8) begin
        a = A_W'($urandom);
        bus.left_in = a;
        if (c >= 4) for (int l = 0; l < LANES; l++) s[l] += longint'(w[0][l]) * longint'(a);
      end
      tick();
      exp_done = (c == 4) || (c == 8);
      checks++;
      if (bus.acc_done_out !== exp_done) begin
        errors++; $display("FAIL ovf_done_pattern tick=%0d got=%b exp=%b", c, bus.acc_done_out, exp_done);
      end
      if (c == 4) begin
        checks++;
        if (bus.ovf_err_out !== 1'b0) begin
          errors++; $display("FAIL ovf_first got=%b exp=0", bus.ovf_err_out);
        end
      end
    end
    checks++;
    if (bus.ovf_err_out !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.ovf_err_out);
    end
    bus.sys_buf_en_in = 1'b1;
    tick();
    bus.sys_buf_en_in = 1'b0;
    checks++;
    if (bus.bottom_out !== pack_drain(s)) begin
      errors++; $display("FAIL ovf_second_sum got=%h exp=%h", bus.bottom_out, pack_drain(s));
    end
  endtask

  task automatic test_reset_mid();
    bus.acc_len_in = CNT_W'(4);
    bus.top_in     = {16'h0, 8'hF9, 8'h05, 16'hABCD};
    bus.y_sel_in   = 1'b1;
    bus.left_in    = 8'h33;
    bus.valid_in   = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.right_out, bus.valid_out, bus.bottom_out, bus.bottom_valid_out, bus.acc_done_out,
         bus.drain_full_out, bus.ovf_err_out} !== '0) begin
      errors++;
      $display("FAIL reset_async got bottom=%h right=%h flags=%b%b%b%b%b exp all 0",
               bus.bottom_out, bus.right_out, bus.valid_out, bus.bottom_valid_out,
               bus.acc_done_out, bus.drain_full_out, bus.ovf_err_out);
    end
    bus.valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.left_in = 8'd1;
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      tick();
      checks++;
      if (bus.acc_done_out !== 1'b0) begin
        errors++; $display("FAIL reset_cnt_early beat=%0d got=%b exp=0", i, bus.acc_done_out);
      end
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.acc_done_out !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_done got=%b exp=1", bus.acc_done_out);
    end
    bus.sys_buf_en_in = 1'b1;
    tick();
    bus.sys_buf_en_in = 1'b0;
    checks++;
    if (bus.bottom_out !== 48'hFFFFE4_000014) begin
      errors++; $display("FAIL reset_bank1_sum got=%h exp=%h", bus.bottom_out, 48'hFFFFE4_000014);
    end
  endtask

  task automatic test_len_zero();
    int pulses, at;
    do_reset();
    bus.acc_len_in = '0;
    bus.top_in     = {32'h0, 8'hFF, 8'h01};
    bus.left_in    = 8'd1;
    pulses = 0;
    at     = -1;
    for (int c = 0; c < 260; c++) begin
      bus.valid_in = (c < 256);
      tick();
      if (bus.acc_done_out === 1'b1) begin
        pulses++;
        at = c;
      end
    end
    checks++;
    if (pulses != 1 || at != 256) begin
      errors++; $display("FAIL len_zero_done got pulses=%0d at=%0d exp 1 at 256", pulses, at);
    end
    bus.sys_buf_en_in = 1'b1;
    tick();
    bus.sys_buf_en_in = 1'b0;
    checks++;
    if (bus.bottom_out !== 48'hFFFF00_000100) begin
      errors++; $display("FAIL len_zero_sum got=%h exp=%h", bus.bottom_out, 48'hFFFF00_000100);
    end
  endtask

  task automatic test_random_mac();
    logic signed [Y_W-1:0] w [Y_BANKS][LANES];
    logic signed [A_W-1:0] a;
    logic [TOP_W-1:0]      e;
    longint s [LANES];
    int n, bank;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      for (int b = 0; b < Y_BANKS; b++)
        for (int l = 0; l < LANES; l++) w[b][l] = Y_W'($urandom);
      n = $urandom_range(1, 6);
      bus.acc_len_in = CNT_W'(n);
      bus.top_in     = pack_w(w);
      for (int l = 0; l < LANES; l++) s[l] = 0;
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.valid_in    = 1'b0;
          bus.mode_sel_in = 2'($urandom);
          tick();
        end
        bank = $urandom_range(0, Y_BANKS - 1);
        a    = A_W'($urandom);
        bus.mode_sel_in = 2'b00;
        bus.y_sel_in    = YSEL_W'(bank);
        bus.left_in     = a;
        bus.valid_in    = 1'b1;
        for (int l = 0; l < LANES; l++) s[l] += longint'(w[bank][l]) * longint'(a);
        tick();
      end
      checks++;
      if (bus.acc_done_out !== 1'b0) begin
        errors++; $display("FAIL rand_done_early grp=%0d got=%b exp=0", g, bus.acc_done_out);
      end
      bus.valid_in    = 1'b0;
      bus.mode_sel_in = 2'($urandom);
      tick();
      checks++;
      if (bus.acc_done_out !== 1'b1 || bus.drain_full_out !== 1'b1) begin
        errors++;
        $display("FAIL rand_done grp=%0d got done=%b full=%b exp 1 1", g, bus.acc_done_out,
                 bus.drain_full_out);
      end
      e = pack_drain(s);
      bus.sys_buf_en_in = 1'b1;
      bus.top_in        = {$urandom, $urandom};
      tick();
      bus.sys_buf_en_in = 1'b0;
      checks++;
      if (bus.bottom_out !== e || bus.bottom_valid_out !== 1'b1 || bus.acc_done_out !== 1'b0) begin
        errors++;
        $display("FAIL rand_sum grp=%0d n=%0d got=%h v=%b done=%b exp=%h v=1 done=0", g, n,
                 bus.bottom_out, bus.bottom_valid_out, bus.acc_done_out, e);
      end
    end
    checks++;
    if (bus.ovf_err_out !== 1'b0) begin
      errors++; $display("FAIL rand_no_ovf got=%b exp=0", bus.ovf_err_out);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_passthrough();
    test_fp();
    test_clear();
    test_collision();
    test_overflow();
    test_reset_mid();
    test_len_zero();
    test_random_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
